// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS writeback path.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_DATA_W  = 32;

    // One pending register-file write at the default result width.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

    // One-hot mask for a destination register; r0 maps to an empty mask.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (r != '0) m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/mips_wb_fifo.sv
// 2-push / 2-pop circular buffer. Entries are exposed in age order
// (index 0 = head = oldest) together with per-entry valid bits.
module mips_wb_fifo
    import mips_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter int  DATA_W = 32,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [1:0]                         push_cnt,
    input  logic [REG_ADDR_W-1:0]              push_reg0,
    input  logic [REG_ADDR_W-1:0]              push_reg1,
    input  logic [DATA_W-1:0]                  push_data0,
    input  logic [DATA_W-1:0]                  push_data1,
    input  logic [1:0]                         pop_cnt,
    output logic [CNT_W-1:0]                   count,
    output logic [DEPTH-1:0]                   ent_vld,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_reg,
    output logic [DEPTH-1:0][DATA_W-1:0]       ent_data
);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [REG_ADDR_W-1:0] reg_q  [DEPTH];
    logic [REG_ADDR_W-1:0] reg_d  [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [DATA_W-1:0]     data_d [DEPTH];

    // Next state: write up to two entries at the tail, advance pointers and count.
    always_comb begin
        reg_d  = reg_q;
        data_d = data_q;
        if (push_cnt != 2'd0) begin
            reg_d[tail_q]  = push_reg0;
            data_d[tail_q] = push_data0;
        end
        if (push_cnt == 2'd2) begin
            reg_d[tail_q + PTR_W'(1)]  = push_reg1;
            data_d[tail_q + PTR_W'(1)] = push_data1;
        end
        tail_d  = tail_q + PTR_W'(push_cnt);
        head_d  = head_q + PTR_W'(pop_cnt);
        count_d = count_q + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
    end

    // State registers; reset discards the whole queue at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
        end
    end

    // Age-ordered view of the buffer, rotated from the head pointer.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_reg[i]  = reg_q[head_q + PTR_W'(i)];
            ent_data[i] = data_q[head_q + PTR_W'(i)];
            ent_vld[i]  = (CNT_W'(i) < count_q);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mips_writeback_queue.sv
// In-order writeback queue feeding a 2-write register file. Accepts results
// from ports A and B, drains up to two per cycle with same-register
// coalescing, and exposes a busy mask plus two forwarding lookups.
module mips_writeback_queue
    import mips_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter int  DATA_W = 32,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0]     a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0]     b_data,
    input  logic                  wb_hold,
    output logic                  RegWriteSign1,
    output logic [REG_ADDR_W-1:0] writeReg1,
    output logic [DATA_W-1:0]     writeData1,
    output logic                  RegWriteSign2,
    output logic [REG_ADDR_W-1:0] writeReg2,
    output logic [DATA_W-1:0]     writeData2,
    output logic [NUM_REGS-1:0]   busy_mask,
    input  logic [REG_ADDR_W-1:0] lk_reg1,
    input  logic [REG_ADDR_W-1:0] lk_reg2,
    output logic                  lk_hit1,
    output logic [DATA_W-1:0]     lk_data1,
    output logic                  lk_hit2,
    output logic [DATA_W-1:0]     lk_data2
);

    logic [CNT_W-1:0]                 count;
    logic [DEPTH-1:0]                 ent_vld;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_reg;
    logic [DEPTH-1:0][DATA_W-1:0]     ent_data;

    logic                  a_push, b_push;
    logic [1:0]            push_cnt, pop_cnt;
    logic [REG_ADDR_W-1:0] push_reg0, push_reg1;
    logic [DATA_W-1:0]     push_data0, push_data1;

    // Ready depends only on the registered occupancy, so there is no
    // valid->ready path and slots freed by this cycle's drain stay unused.
    assign a_ready = (count <= CNT_W'(DEPTH - 1));
    assign b_ready = (count <= CNT_W'(DEPTH - 2));

    // Accept handshakes, drop r0 results, and pack the survivors A-before-B.
    always_comb begin
        a_push     = a_valid && a_ready && (a_reg != '0);
        b_push     = b_valid && b_ready && (b_reg != '0);
        push_cnt   = {1'b0, a_push} + {1'b0, b_push};
        push_reg0  = a_push ? a_reg  : b_reg;
        push_data0 = a_push ? a_data : b_data;
        push_reg1  = b_reg;
        push_data1 = b_data;
    end

    mips_wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_cnt   (push_cnt),
        .push_reg0  (push_reg0),
        .push_reg1  (push_reg1),
        .push_data0 (push_data0),
        .push_data1 (push_data1),
        .pop_cnt    (pop_cnt),
        .count      (count),
        .ent_vld    (ent_vld),
        .ent_reg    (ent_reg),
        .ent_data   (ent_data)
    );

    // Drain the two oldest entries; when both target the same register only
    // the younger value is written, but both are retired.
    always_comb begin
        RegWriteSign1 = 1'b0;
        writeReg1     = '0;
        writeData1    = '0;
        RegWriteSign2 = 1'b0;
        writeReg2     = '0;
        writeData2    = '0;
        pop_cnt       = 2'd0;
        if (!wb_hold) begin
            if (ent_vld[1]) begin
                pop_cnt       = 2'd2;
                RegWriteSign1 = 1'b1;
                if (ent_reg[0] == ent_reg[1]) begin
                    writeReg1  = ent_reg[1];
                    writeData1 = ent_data[1];
                end else begin
                    writeReg1     = ent_reg[0];
                    writeData1    = ent_data[0];
                    RegWriteSign2 = 1'b1;
                    writeReg2     = ent_reg[1];
                    writeData2    = ent_data[1];
                end
            end else if (ent_vld[0]) begin
                pop_cnt       = 2'd1;
                RegWriteSign1 = 1'b1;
                writeReg1     = ent_reg[0];
                writeData1    = ent_data[0];
            end
        end
    end

    // Busy mask and forwarding over every queued entry, including those
    // draining now; scanning oldest to youngest leaves the youngest match.
    always_comb begin
        busy_mask = '0;
        lk_hit1   = 1'b0;
        lk_data1  = '0;
        lk_hit2   = 1'b0;
        lk_data2  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) begin
                busy_mask = busy_mask | reg_onehot(ent_reg[i]);
                if ((lk_reg1 != '0) && (ent_reg[i] == lk_reg1)) begin
                    lk_hit1  = 1'b1;
                    lk_data1 = ent_data[i];
                end
                if ((lk_reg2 != '0) && (ent_reg[i] == lk_reg2)) begin
                    lk_hit2  = 1'b1;
                    lk_data2 = ent_data[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_writeback_queue.sv
// Scoreboard bench for mips_writeback_queue: stimulus pushes expected writes,
// a negedge monitor pops them as the write ports fire.
module tb_mips_writeback_queue;
    import mips_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        a_valid, b_valid, wb_hold;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg, b_reg, lk_reg1, lk_reg2;
    logic [31:0] a_data, b_data;
    logic        RegWriteSign1, RegWriteSign2;
    logic [4:0]  writeReg1, writeReg2;
    logic [31:0] writeData1, writeData2;
    logic [31:0] busy_mask;
    logic        lk_hit1, lk_hit2;
    logic [31:0] lk_data1, lk_data2;

    int          checks = 0;
    int          errors = 0;
    wb_entry_t   sb[$];
    wb_entry_t   mon_e;
    bit          a_acc, b_acc;

    mips_writeback_queue #(.DEPTH(4), .DATA_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .wb_hold(wb_hold),
        .RegWriteSign1(RegWriteSign1), .writeReg1(writeReg1), .writeData1(writeData1),
        .RegWriteSign2(RegWriteSign2), .writeReg2(writeReg2), .writeData2(writeData2),
        .busy_mask(busy_mask),
        .lk_reg1(lk_reg1), .lk_reg2(lk_reg2),
        .lk_hit1(lk_hit1), .lk_data1(lk_data1),
        .lk_hit2(lk_hit2), .lk_data2(lk_data2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every write the DUT issues must match the oldest expected entry.
    always @(negedge clock) begin
        if (reset_n) begin
            if (RegWriteSign1) begin
                if (sb.size() == 0) chk("wr1_unexpected", 64'({writeReg1, writeData1}), 64'(0) - 64'(1));
                else begin
                    mon_e = sb.pop_front();
                    chk("wr1", 64'({writeReg1, writeData1}), 64'(mon_e));
                end
            end else chk("wr1_idle", 64'({writeReg1, writeData1}), 64'(0));
            if (RegWriteSign2) begin
                chk("wr2_needs_wr1", 64'(RegWriteSign1), 64'(1));
                if (sb.size() == 0) chk("wr2_unexpected", 64'({writeReg2, writeData2}), 64'(0) - 64'(1));
                else begin
                    mon_e = sb.pop_front();
                    chk("wr2", 64'({writeReg2, writeData2}), 64'(mon_e));
                end
            end else chk("wr2_idle", 64'({writeReg2, writeData2}), 64'(0));
        end
    end

    // One cycle of stimulus, entered just after a posedge; returns just after the next.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic bv, input logic [4:0] br, input logic [31:0] bd,
                        input logic hold, input bit auto_exp);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        wb_hold = hold;
        @(negedge clock);
        a_acc = av && a_ready;
        b_acc = bv && b_ready;
        if (auto_exp) begin
            if (a_acc && ar != 0) sb.push_back(wb_entry_t'{rd: ar, data: ad});
            if (b_acc && br != 0) sb.push_back(wb_entry_t'{rd: br, data: bd});
        end
        @(posedge clock); #1;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        logic [4:0]  ar, br, last, lk;
        logic [31:0] exp_busy, exp_d;
        logic        exp_h;
        reset_n = 1'b0;
        a_valid = 0; b_valid = 0; a_reg = 0; b_reg = 0; a_data = 0; b_data = 0;
        wb_hold = 0; lk_reg1 = 0; lk_reg2 = 0;
        #12;
        chk("rst_a_ready", 64'(a_ready), 64'(1));
        chk("rst_b_ready", 64'(b_ready), 64'(1));
        chk("rst_busy", 64'(busy_mask), 64'(0));
        chk("rst_we", 64'({RegWriteSign1, RegWriteSign2}), 64'(0));
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Dual enqueue, dual write next cycle.
        step(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 1);
        chk("dual_we1", 64'(RegWriteSign1), 64'(1));
        chk("dual_we2", 64'(RegWriteSign2), 64'(1));
        @(posedge clock); #1;

        // Same register on consecutive cycles under hold coalesces to the younger value.
        step(1, 5'd5, 32'hAA, 0, 5'd0, 32'h0, 1, 0);
        step(0, 5'd0, 32'h0, 1, 5'd5, 32'hBB, 1, 0);
        chk("coal_b_acc", 64'(b_acc), 64'(1));
        sb.push_back(wb_entry_t'{rd: 5'd5, data: 32'hBB});
        wb_hold = 1'b0; #1;
        chk("coal_we", 64'({RegWriteSign1, RegWriteSign2}), 64'(2'b10));
        chk("coal_wr1", 64'({writeReg1, writeData1}), {27'd0, 5'd5, 32'hBB});
        @(posedge clock); #1;

        // Fill to DEPTH under hold.
        step(1, 5'd1, 32'h101, 1, 5'd2, 32'h102, 1, 1);
        step(1, 5'd3, 32'h103, 0, 5'd0, 32'h0, 1, 1);
        chk("cnt3_a_ready", 64'(a_ready), 64'(1));
        chk("cnt3_b_ready", 64'(b_ready), 64'(0));
        step(1, 5'd6, 32'h106, 1, 5'd8, 32'h108, 1, 1);
        chk("cnt3_b_rej", 64'(b_acc), 64'(0));
        chk("full_a_ready", 64'(a_ready), 64'(0));
        chk("full_b_ready", 64'(b_ready), 64'(0));
        chk("full_busy", 64'(busy_mask), 64'(32'h4E));
        step(1, 5'd9, 32'h109, 1, 5'd10, 32'h10A, 1, 1);
        chk("full_rej", 64'({a_acc, b_acc}), 64'(0));
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1);
        chk("fill_drained", 64'(sb.size()), 64'(0));

        // r0 completes the handshake but is never queued.
        step(1, 5'd0, 32'hFF, 0, 5'd0, 32'h0, 0, 1);
        chk("r0_acc", 64'(a_acc), 64'(1));
        chk("r0_busy", 64'(busy_mask), 64'(0));
        lk_reg1 = 5'd0; #1;
        chk("r0_lk", 64'({lk_hit1, lk_data1}), 64'(0));

        // Youngest-match forwarding and busy mask on a held duplicate pair.
        step(1, 5'd7, 32'h1, 1, 5'd7, 32'h2, 1, 0);
        chk("dup_busy", 64'(busy_mask), 64'(32'h80));
        lk_reg2 = 5'd7; lk_reg1 = 5'd8; #1;
        chk("dup_lk2", 64'({lk_hit2, lk_data2}), {31'd0, 1'b1, 32'h2});
        chk("dup_lk1_miss", 64'({lk_hit1, lk_data1}), 64'(0));
        sb.push_back(wb_entry_t'{rd: 5'd7, data: 32'h2});
        wb_hold = 1'b0; #1;
        chk("dup_we", 64'({RegWriteSign1, RegWriteSign2}), 64'(2'b10));
        chk("dup_busy_draining", 64'(busy_mask), 64'(32'h80));
        @(posedge clock); #1;
        chk("dup_busy_after", 64'(busy_mask), 64'(0));

        // Asynchronous reset while draining.
        step(1, 5'd1, 32'h5, 1, 5'd2, 32'h6, 1, 1);
        wb_hold = 1'b0; #1;
        chk("mid_drain_we", 64'(RegWriteSign1), 64'(1));
        reset_n = 1'b0; #1;
        chk("arst_we", 64'({RegWriteSign1, RegWriteSign2}), 64'(0));
        chk("arst_busy", 64'(busy_mask), 64'(0));
        chk("arst_ready", 64'({a_ready, b_ready}), 64'(2'b11));
        sb.delete();
        @(posedge clock); #2;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Random soak with pointer wrap; adjacent queued regs kept distinct.
        last = 0;
        for (int n = 0; n < 300; n++) begin
            do ar = 5'($urandom_range(0, 31)); while (ar != 0 && ar == last);
            do br = 5'($urandom_range(0, 31)); while (br != 0 && (br == last || br == ar));
            step(1'($urandom_range(0, 1)), ar, $urandom, 1'($urandom_range(0, 1)), br, $urandom,
                 1'($urandom_range(0, 3) == 0), 1);
            if (a_acc && ar != 0) last = ar;
            if (b_acc && br != 0) last = br;
            lk = 5'($urandom_range(0, 31));
            lk_reg1 = lk;
            exp_busy = 0; exp_h = 0; exp_d = 0;
            foreach (sb[i]) begin
                exp_busy[sb[i].rd] = 1'b1;
                if (lk != 0 && sb[i].rd == lk) begin exp_h = 1; exp_d = sb[i].data; end
            end
            #1;
            chk("soak_busy", 64'(busy_mask), 64'(exp_busy));
            chk("soak_lk1", 64'({lk_hit1, lk_data1}), 64'({exp_h, exp_d}));
            chk("soak_ready", 64'({a_ready, b_ready}), 64'({sb.size() <= 3, sb.size() <= 2}));
        end

        wb_hold = 1'b0;
        for (int n = 0; n < 8 && sb.size() != 0; n++) begin
            @(posedge clock); #1;
        end
        chk("final_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
